sram_bank_ctrl: RTL and testbench
=================================

Name: sram_bank_ctrl

Overview:
Parametrised controller for NBANK parallel external asynchronous SRAM banks that share one address bus. It replaces fixed four-bank wiring with a single FSM that owns the pins. It has two modes, arbitrated internally:
- Init streaming: a narrow DATAW word stream is packed into NBANK-wide rows and written with timed WR pulses.
- Lookup: a single-address read request returns the full NBANK*DATAW row after a programmable access latency.
Pad tristating stays outside the block; the block drives the output data bus and an output-enable.

Parameters:
ADDRW, 19, SRAM address width
DATAW, 32, data width per bank
NBANK, 4, number of banks (at least 1)
WR_CYC, 2, cycles WR_n is held low per write (at least 1)
RD_LAT, 2, cycles from address/OE valid to data capture (at least 1)

Ports:
CLK  in  1  clock
RSTn  in  1  synchronous active-low reset
init_start  in  1  pulse: begin init load; sampled only in IDLE
init_rows  in  ADDRW  rows to write, captured at init_start; 0 means 2^ADDRW
init_valid  in  1  init word valid
init_data  in  DATAW  init word; word k of a row goes to bank k
init_ready  out  1  init word accepted when init_valid && init_ready
init_busy  out  1  init sequence in progress
init_done  out  1  one-cycle pulse after the last row is written
rd_valid  in  1  lookup request valid
rd_addr  in  ADDRW  lookup address
rd_ready  out  1  request accepted when rd_valid && rd_ready
rsp_valid  out  1  one-cycle pulse: rsp_data valid
rsp_data  out  NBANK*DATAW  captured row; bank k at bits [DATAW*k+DATAW-1 : DATAW*k]; held until next capture
SRAM_CS_n  out  NBANK  chip selects, active low
SRAM_WR_n  out  NBANK  write strobes, active low
SRAM_OE_n  out  1  output enable, active low
SRAM_ADDR  out  ADDRW  shared address
SRAM_DQ_O  out  NBANK*DATAW  write data to pads
SRAM_DQ_OE  out  1  1 = pads driven by SRAM_DQ_O
SRAM_DQ_I  in  NBANK*DATAW  read data from pads

Behaviour:
- Reset values (RSTn low at a CLK edge):
  - State is IDLE.
  - CS_n, WR_n and OE_n are all ones.
  - DQ_OE = 0, ADDR = 0, DQ_O = 0.
  - init_ready, init_busy, init_done, rd_ready, rsp_valid are 0; rsp_data = 0.
  - Row and word counters are 0.
- Reset mid-operation: the sequence is aborted and no further pin activity occurs. A partially written SRAM row is not retried.
- States: IDLE, FILL, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACC, RD_DONE.
- IDLE:
  - rd_ready = 1 unless init_start = 1.
  - init_start has priority over a same-cycle rd_valid. Init_start goes to FILL, captures init_rows, clears row_cnt, and sets init_busy.
  - An accepted read latches rd_addr and goes to RD_ACC.
- FILL:
  - init_ready = 1. Each accepted word is stored in slot word_cnt; word_cnt increments.
  - On acceptance of word NBANK-1, go to WR_SETUP and clear word_cnt. Stalls on init_valid are unlimited.
- WR_SETUP (1 cycle): ADDR = row_cnt, DQ_O = packed row, DQ_OE = 1, CS_n all 0, WR_n all 1.
- WR_PULSE (WR_CYC cycles): as WR_SETUP, but WR_n all 0.
- WR_HOLD (1 cycle): WR_n all 1; DQ and ADDR are held. Then:
  - If row_cnt == rows-1: pulse init_done, clear init_busy, go to IDLE.
  - Otherwise: row_cnt++, go to FILL.
  - row_cnt wraps 2^ADDRW-1 to 0 only in the rows = 0 case; that case finishes at row 2^ADDRW-1.
- RD_ACC (RD_LAT cycles): ADDR = latched addr, CS_n all 0, OE_n = 0, DQ_OE = 0. On the last cycle, rsp_data <= SRAM_DQ_I.
- RD_DONE (1 cycle): rsp_valid = 1, pins return to idle, go to IDLE.
  - Read latency: request accepted at edge 0, rsp_valid high in cycle RD_LAT+1.
  - Throughput is one read per RD_LAT+2 cycles.
- DQ_OE and OE_n low are never asserted in the same cycle.
- At least one cycle of DQ_OE = 0 separates a write from a following read.
- Pins are registered outputs.
- Reads are not accepted while init_busy is set.

Test Plan:
1. Reset hold, then release → all outputs at their reset values. With rd_valid low, pins stay idle for 20 cycles.
2. NBANK=4, WR_CYC=2, init_rows=2, words 0x11,0x22,…,0x88 with no stalls:
   - two writes with ADDR 0 then 1;
   - row 0 DQ_O = {0x44,0x33,0x22,0x11};
   - WR_n low exactly 2 cycles per row;
   - init_done pulses once; init_busy falls with it.
3. Init with init_valid toggled 1-0-1 each cycle → the same packed rows as scenario 2. No write starts before the 4th word is accepted.
4. Read rd_addr=0x1, with the SRAM model returning the written data → rsp_valid in cycle RD_LAT+1 = 3 after acceptance; rsp_data = {0x88,0x77,0x66,0x55}. DQ_OE = 0 throughout.
5. init_start and rd_valid asserted in the same IDLE cycle → init wins and rd_ready = 0. The read is accepted only after init_done; no OE_n/DQ_OE overlap at any point.
6. RSTn low during WR_PULSE of row 1 → next cycle WR_n and CS_n are all 1, init_busy = 0, and no init_done is produced. A new init_start then runs normally.

Source files
------------

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: packs init words into NBANK-wide SRAM rows and serves single-row lookups over a shared bus
module sram_bank_ctrl #(
  parameter int ADDRW  = 19,
  parameter int DATAW  = 32,
  parameter int NBANK  = 4,
  parameter int WR_CYC = 2,
  parameter int RD_LAT = 2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   init_start,
  input  logic [ADDRW-1:0]       init_rows,
  input  logic                   init_valid,
  input  logic [DATAW-1:0]       init_data,
  output logic                   init_ready,
  output logic                   init_busy,
  output logic                   init_done,
  input  logic                   rd_valid,
  input  logic [ADDRW-1:0]       rd_addr,
  output logic                   rd_ready,
  output logic                   rsp_valid,
  output logic [NBANK*DATAW-1:0] rsp_data,
  output logic [NBANK-1:0]       SRAM_CS_n,
  output logic [NBANK-1:0]       SRAM_WR_n,
  output logic                   SRAM_OE_n,
  output logic [ADDRW-1:0]       SRAM_ADDR,
  output logic [NBANK*DATAW-1:0] SRAM_DQ_O,
  output logic                   SRAM_DQ_OE,
  input  logic [NBANK*DATAW-1:0] SRAM_DQ_I
);
  localparam int WCW = NBANK > 1 ? $clog2(NBANK) : 1;
  localparam int MXC = WR_CYC > RD_LAT ? WR_CYC : RD_LAT;
  localparam int CW  = $clog2(MXC + 1);
  localparam int RW  = NBANK * DATAW;
  typedef enum logic [2:0] {IDLE, FILL, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACC, RD_DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [ADDRW-1:0] row_cnt_q, row_cnt_d, rows_q, rows_d, raddr_q, raddr_d, addr_q, addr_d;
  logic [DATAW-1:0] words_q [NBANK];
  logic [DATAW-1:0] words_d [NBANK];
  logic [RW-1:0]    dq_o_q, dq_o_d, rsp_data_q, rsp_data_d, packed_row;
  logic [NBANK-1:0] cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic             oe_n_q, oe_n_d, dq_oe_q, dq_oe_d, busy_q, busy_d;
  logic             done_q, done_d, rsp_valid_q, rsp_valid_d, wr_phase, rd_phase;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_cnt_d  = word_cnt_q;
    row_cnt_d   = row_cnt_q;
    rows_d      = rows_q;
    raddr_d     = raddr_q;
    words_d     = words_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d    = FILL;
          rows_d     = init_rows;
          row_cnt_d  = '0;
          word_cnt_d = '0;
          busy_d     = 1'b1;
        end else if (rd_valid) begin
          state_d = RD_ACC;
          raddr_d = rd_addr;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (init_valid) begin
          words_d[word_cnt_q] = init_data;
          state_d    = word_cnt_q == WCW'(NBANK - 1) ? WR_SETUP : FILL;
          word_cnt_d = word_cnt_q == WCW'(NBANK - 1) ? '0 : word_cnt_q + WCW'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
      end
      WR_PULSE: begin
        state_d = cnt_q == CW'(WR_CYC - 1) ? WR_HOLD : WR_PULSE;
        cnt_d   = cnt_q + CW'(1);
      end
      WR_HOLD: begin
        // rows_q of 0 wraps to all ones, so a full 2^ADDRW pass ends at the top row
        if (row_cnt_q == rows_q - ADDRW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = FILL;
          row_cnt_d = row_cnt_q + ADDRW'(1);
        end
      end
      RD_ACC: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d     = RD_DONE;
          rsp_data_d  = SRAM_DQ_I;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    packed_row = '0;
    for (int k = 0; k < NBANK; k++) packed_row[k*DATAW +: DATAW] = words_d[k];
    // pins are registered from the next state so they line up with the state they belong to
    wr_phase = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    rd_phase = state_d == RD_ACC;
    cs_n_d   = (wr_phase || rd_phase) ? '0 : '1;
    wr_n_d   = state_d == WR_PULSE ? '0 : '1;
    oe_n_d   = !rd_phase;
    dq_oe_d  = wr_phase;
    addr_d   = state_d == WR_SETUP ? row_cnt_d : rd_phase ? raddr_d : addr_q;
    dq_o_d   = state_d == WR_SETUP ? packed_row : dq_o_q;
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_cnt_q  <= '0;
      row_cnt_q   <= '0;
      rows_q      <= '0;
      raddr_q     <= '0;
      words_q     <= '{default: '0};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cs_n_q      <= '1;
      wr_n_q      <= '1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      row_cnt_q   <= row_cnt_d;
      rows_q      <= rows_d;
      raddr_q     <= raddr_d;
      words_q     <= words_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
    end
  end
  assign init_ready = state_q == FILL;
  assign rd_ready   = RSTn && state_q == IDLE && !init_start;
  assign init_busy  = busy_q;
  assign init_done  = done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign SRAM_CS_n  = cs_n_q;
  assign SRAM_WR_n  = wr_n_q;
  assign SRAM_OE_n  = oe_n_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_DQ_O  = dq_o_q;
  assign SRAM_DQ_OE = dq_oe_q;
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl: vector table, directed corner sequences and randomized init/lookup against a row-level model
module tb_sram_bank_ctrl;
  localparam int AW = 19, DW = 32, NB = 4, RW = 128, WR_CYC = 2, RD_LAT = 2;
  logic CLK = 0, RSTn = 0;
  logic init_start = 0, init_valid = 0, rd_valid = 0;
  logic [AW-1:0] init_rows = '0, rd_addr = '0;
  logic [DW-1:0] init_data = '0;
  logic init_ready, init_busy, init_done, rd_ready, rsp_valid, SRAM_OE_n, SRAM_DQ_OE;
  logic [RW-1:0] rsp_data, SRAM_DQ_O, SRAM_DQ_I;
  logic [NB-1:0] SRAM_CS_n, SRAM_WR_n;
  logic [AW-1:0] SRAM_ADDR;
  always #5 CLK = ~CLK;
  sram_bank_ctrl #(.ADDRW(AW), .DATAW(DW), .NBANK(NB), .WR_CYC(WR_CYC), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .init_start(init_start), .init_rows(init_rows), .init_valid(init_valid),
    .init_data(init_data), .init_ready(init_ready), .init_busy(init_busy), .init_done(init_done),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .SRAM_CS_n(SRAM_CS_n), .SRAM_WR_n(SRAM_WR_n), .SRAM_OE_n(SRAM_OE_n), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DQ_I(SRAM_DQ_I));
  logic [RW-1:0] mem [256];
  assign SRAM_DQ_I = SRAM_OE_n ? '0 : mem[SRAM_ADDR[7:0]];
  always @(posedge CLK)
    for (int k = 0; k < NB; k++)
      if (!SRAM_CS_n[k] && !SRAM_WR_n[k] && SRAM_DQ_OE) mem[SRAM_ADDR[7:0]][k*DW +: DW] <= SRAM_DQ_O[k*DW +: DW];
  int acc_total = 0, done_cnt = 0, overlap = 0, gap_viol = 0, busy_viol = 0, rd_acc_busy = 0, acc_done_mark = 0, wr_run = 0;
  logic prev_dqoe = 0;
  logic [AW-1:0] wl_addr[$];
  logic [RW-1:0] wl_data[$];
  int wr_runs[$], wst_acc[$];
  initial forever begin
    @(negedge CLK);
    if (!RSTn) begin
      wr_run = 0;
      prev_dqoe = 0;
    end else begin
      if (init_valid && init_ready) acc_total++;
      if (SRAM_DQ_OE && !prev_dqoe) wst_acc.push_back(acc_total);
      if (SRAM_WR_n != '1) begin
        if (wr_run == 0) begin wl_addr.push_back(SRAM_ADDR); wl_data.push_back(SRAM_DQ_O); end
        wr_run++;
      end else if (wr_run > 0) begin
        wr_runs.push_back(wr_run);
        wr_run = 0;
      end
      if (!SRAM_OE_n && SRAM_DQ_OE) overlap++;
      if (!SRAM_OE_n && prev_dqoe) gap_viol++;
      if (init_done) begin done_cnt++; if (init_busy) busy_viol++; end
      if (rd_valid && rd_ready) begin if (init_busy || init_start) rd_acc_busy++; acc_done_mark = done_cnt; end
      prev_dqoe = SRAM_DQ_OE;
    end
  end
  int passed = 0, total = 0;
  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [RW-1:0] pack_row(input logic [DW-1:0] w[$], input int r);
    logic [RW-1:0] row = '0;
    for (int k = NB - 1; k >= 0; k--) row = (row << DW) | RW'(w[r*NB + k]);
    return row;
  endfunction
  task automatic start_init(input logic [AW-1:0] rows);
    init_start = 1;
    init_rows = rows;
    tick();
    init_start = 0;
  endtask
  task automatic feed(input logic [DW-1:0] w[$], input int mode);
    int i = 0;
    logic ph = 1;
    for (int t = 0; t < 400 && i < w.size(); t++) begin
      init_valid = mode == 0 ? 1'b1 : mode == 1 ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      init_data = w[i];
      @(negedge CLK);
      if (init_valid && init_ready) i++;
      tick();
    end
    init_valid = 0;
    chk("feed_words", i, w.size());
  endtask
  task automatic run_init(input logic [AW-1:0] rows, input logic [DW-1:0] w[$], input int mode, input logic [RW-1:0] er[$]);
    int wb = wl_addr.size(), rb = wr_runs.size(), sb = wst_acc.size(), ab = acc_total, db = done_cnt, bb = busy_viol;
    start_init(rows);
    chk("init_busy_set", init_busy, 1);
    feed(w, mode);
    for (int t = 0; t < 100 && done_cnt == db; t++) tick();
    repeat (3) tick();
    chk("init_done_once", done_cnt - db, 1);
    chk("busy_falls_with_done", busy_viol - bb, 0);
    chk("init_busy_clear", init_busy, 0);
    chk("write_count", wl_addr.size() - wb, er.size());
    for (int j = 0; j < er.size(); j++) begin
      chk("write_addr", wl_addr[wb+j], j);
      chk("write_data", wl_data[wb+j], er[j]);
      chk("wr_low_cycles", wr_runs[rb+j], WR_CYC);
      chk("write_after_words", wst_acc[sb+j] - ab, NB * (j + 1));
    end
  endtask
  task automatic do_read(input logic [AW-1:0] a, output logic [RW-1:0] d, output int lat);
    bit acc = 0;
    rd_valid = 1;
    rd_addr = a;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge CLK);
      acc = rd_ready;
      tick();
    end
    rd_valid = 0;
    chk("rd_accept", acc, 1);
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      lat++;
      if (rsp_valid) break;
    end
    d = rsp_data;
    tick();
  endtask
  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] exp_data;
    int exp_lat;
  } vec_t;
  localparam logic [RW-1:0] ROW0 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [RW-1:0] ROW1 = 128'h00000088_00000077_00000066_00000055;
  initial begin
    vec_t tbl[4];
    logic [DW-1:0] w[$], w5[$], w6[$], w7[$], wr[$];
    logic [RW-1:0] er[$], d;
    int lat, bad, db, found;
    logic [AW-1:0] a;
    tbl[0] = '{1, ROW1, RD_LAT + 1};
    tbl[1] = '{0, ROW0, RD_LAT + 1};
    tbl[2] = '{1, ROW1, RD_LAT + 1};
    tbl[3] = '{0, ROW0, RD_LAT + 1};
    w  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
    w5 = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    w6 = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7, 32'hB8};
    w7 = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cs_n", SRAM_CS_n, 4'hF);
    chk("rst_wr_n", SRAM_WR_n, 4'hF);
    chk("rst_oe_n", SRAM_OE_n, 1);
    chk("rst_dq_oe", SRAM_DQ_OE, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_dq_o", SRAM_DQ_O, 0);
    chk("rst_init_ready", init_ready, 0);
    chk("rst_init_busy", init_busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    RSTn = 1;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (SRAM_CS_n != 4'hF || SRAM_WR_n != 4'hF || !SRAM_OE_n || SRAM_DQ_OE) bad++;
    end
    chk("idle_pins_20", bad, 0);
    chk("idle_rd_ready", rd_ready, 1);
    tick();
    er = '{ROW0, ROW1};
    run_init(2, w, 0, er);
    run_init(2, w, 1, er);
    for (int i = 0; i < 4; i++) begin
      do_read(tbl[i].addr, d, lat);
      chk("tbl_rd_data", d, tbl[i].exp_data);
      chk("tbl_rd_lat", lat, tbl[i].exp_lat);
    end
    repeat (3) tick();
    chk("rsp_data_held", rsp_data, ROW0);
    db = done_cnt;
    rd_valid = 1;
    rd_addr = 0;
    init_start = 1;
    init_rows = 1;
    @(negedge CLK);
    chk("start_beats_read", rd_ready, 0);
    tick();
    init_start = 0;
    feed(w5, 0);
    found = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (rsp_valid) begin found = 1; break; end
    end
    rd_valid = 0;
    chk("contend_rsp_seen", found, 1);
    chk("contend_rsp_data", rsp_data, 128'h000000A4_000000A3_000000A2_000000A1);
    chk("contend_no_busy_accept", rd_acc_busy, 0);
    chk("contend_accept_after_done", acc_done_mark - db, 1);
    tick();
    db = done_cnt;
    start_init(2);
    feed(w6, 0);
    found = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (SRAM_WR_n != '1 && SRAM_ADDR == 1) begin found = 1; break; end
    end
    chk("abort_in_pulse", found, 1);
    RSTn = 0;
    @(negedge CLK);
    chk("abort_wr_n", SRAM_WR_n, 4'hF);
    chk("abort_cs_n", SRAM_CS_n, 4'hF);
    chk("abort_busy", init_busy, 0);
    chk("abort_dq_oe", SRAM_DQ_OE, 0);
    @(negedge CLK);
    RSTn = 1;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (SRAM_CS_n != 4'hF || SRAM_WR_n != 4'hF || !SRAM_OE_n || SRAM_DQ_OE) bad++;
    end
    chk("abort_pins_quiet", bad, 0);
    chk("abort_no_done", done_cnt - db, 0);
    tick();
    er = '{128'h000000C4_000000C3_000000C2_000000C1};
    run_init(1, w7, 0, er);
    do_read(0, d, lat);
    chk("reinit_rd_data", d, er[0]);
    wr = {};
    for (int i = 0; i < 3 * NB; i++) wr.push_back($urandom);
    er = {};
    for (int r = 0; r < 3; r++) er.push_back(pack_row(wr, r));
    run_init(3, wr, 2, er);
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range(0, 2));
      do_read(a, d, lat);
      chk("rand_rd_data", d, er[a]);
      chk("rand_rd_lat", lat, RD_LAT + 1);
    end
    chk("no_oe_dqoe_overlap", overlap, 0);
    chk("dqoe_gap_before_read", gap_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
